// File: rtl/ahb2_pkg.sv
// rtl/ahb2_pkg.sv - shared AHB2 encodings and SRAM slave state type
package ahb2_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR1 = 2'd2;
  localparam state_t ST_ERR2 = 2'd3;

endpackage

// File: rtl/ahb2_sram_slv_if.sv
// rtl/ahb2_sram_slv_if.sv - AHB2 slave-side bus bundle
interface ahb2_sram_slv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic                  hreadyi;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyo;
  logic [1:0]            hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hreadyi, hwdata,
    input  hrdata, hreadyo, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hreadyi, hwdata,
    output hrdata, hreadyo, hresp
  );
endinterface

// File: rtl/ahb2_byte_mask.sv
// rtl/ahb2_byte_mask.sv - little-endian lane mask and size/alignment check
module ahb2_byte_mask
  import ahb2_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int LB         = $clog2(NB)
) (
  input  logic [2:0]    hsize,
  input  logic [LB-1:0] addr_lo,
  output logic [NB-1:0] mask,
  output logic          align_err
);
  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;

  always_comb begin
    mask      = '0;
    align_err = 1'b0;
    if (hsize > MAX_SIZE) begin
      align_err = 1'b1;
    end else begin
      if ((int'(addr_lo) & ((1 << hsize) - 1)) != 0) align_err = 1'b1;
      for (int i = 0; i < NB; i++)
        mask[i] = (i >= int'(addr_lo)) && (i < int'(addr_lo) + (1 << hsize));
    end
  end
endmodule

// File: rtl/ahb2_sram_slv.sv
// rtl/ahb2_sram_slv.sv - AHB2 SRAM slave with wait states, ERROR response and RAW forwarding
module ahb2_sram_slv
  import ahb2_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input logic             clk,
  input logic             rst_n,
  ahb2_sram_slv_if.slave  bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int IW    = ADDR_WIDTH - LB;
  localparam int DEPTH = 1 << IW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [IW-1:0]         dp_idx_q, dp_idx_d;
  logic [NB-1:0]         dp_mask_q, dp_mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept, illegal, align_err, range_err, complete, commit;
  logic [NB-1:0]         new_mask;
  logic [IW-1:0]         new_idx;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic                  unused_hburst;

  assign unused_hburst = ^bus.hburst;

  ahb2_byte_mask #(.DATA_WIDTH(DATA_WIDTH)) u_byte_mask (
    .hsize     (bus.hsize),
    .addr_lo   (bus.haddr[LB-1:0]),
    .mask      (new_mask),
    .align_err (align_err)
  );

  assign range_err = (bus.haddr >> ADDR_WIDTH) != 32'd0;
  assign illegal   = align_err | range_err;
  assign new_idx   = bus.haddr[ADDR_WIDTH-1:LB];
  assign accept    = bus.hsel && bus.hreadyi &&
                     (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
  assign complete  = dp_valid_q && (state_q == ST_IDLE);
  assign commit    = complete && dp_write_q;

  assign bus.hreadyo = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign bus.hresp   = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata  = (complete && !dp_write_q) ? rdata_q : '0;

  // A read accepted while the previous write commits sees that write's lanes.
  always_comb begin
    fwd_word = mem[new_idx];
    if (commit && dp_idx_q == new_idx) begin
      for (int i = 0; i < NB; i++)
        if (dp_mask_q[i]) fwd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_mask_d  = dp_mask_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d    = ST_IDLE;
        dp_valid_d = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = bus.hwrite;
            dp_idx_d   = new_idx;
            dp_mask_d  = new_mask;
            rdata_d    = fwd_word;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 3'(WAIT_STATES);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_mask_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_mask_q  <= dp_mask_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < NB; i++)
        if (dp_mask_q[i]) mem[dp_idx_q][8*i +: 8] <= bus.hwdata[8*i +: 8];
    end
  end

`ifndef SYNTHESIS
  task init_mem(input logic [DATA_WIDTH-1:0] val);
    for (int i = 0; i < DEPTH; i++) mem[i] <= val;
  endtask

  task read_word(input logic [IW-1:0] idx, output logic [DATA_WIDTH-1:0] val);
    val = mem[idx];
  endtask

  task write_word(input logic [IW-1:0] idx, input logic [DATA_WIDTH-1:0] val);
    mem[idx] <= val;
  endtask
`endif
endmodule

// File: tb/tb_ahb2_sram_slv.sv
// tb/tb_ahb2_sram_slv.sv - randomized bench for ahb2_sram_slv against a byte-level reference model
module tb_ahb2_sram_slv;
  import ahb2_pkg::*;

  typedef struct {
    int          kind;   // 0 transfer, 1 IDLE, 2 BUSY, 3 NONSEQ with hsel low
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    bit          has_exp;
    logic [63:0] exp;
  } op_t;

  localparam int AW = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cur = 0;
  logic        sel_en;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;

  int total = 0;
  int bad = 0;
  logic [7:0] ref_mem [int];
  int dw_of [3] = '{32, 64, 32};
  int ws_of [3] = '{0, 2, 3};

  always #5 clk = ~clk;

  ahb2_sram_slv_if #(.DATA_WIDTH(32)) if0 ();
  ahb2_sram_slv_if #(.DATA_WIDTH(64)) if1 ();
  ahb2_sram_slv_if #(.DATA_WIDTH(32)) if2 ();

  assign if0.hsel = sel_en && (cur == 0);
  assign if1.hsel = sel_en && (cur == 1);
  assign if2.hsel = sel_en && (cur == 2);
  assign if0.haddr = haddr;   assign if1.haddr = haddr;   assign if2.haddr = haddr;
  assign if0.htrans = htrans; assign if1.htrans = htrans; assign if2.htrans = htrans;
  assign if0.hwrite = hwrite; assign if1.hwrite = hwrite; assign if2.hwrite = hwrite;
  assign if0.hsize = hsize;   assign if1.hsize = hsize;   assign if2.hsize = hsize;
  assign if0.hburst = 3'b001; assign if1.hburst = 3'b011; assign if2.hburst = 3'b000;
  assign if0.hreadyi = if0.hreadyo;
  assign if1.hreadyi = if1.hreadyo;
  assign if2.hreadyi = if2.hreadyo;
  assign if0.hwdata = hwdata[31:0];
  assign if1.hwdata = hwdata;
  assign if2.hwdata = hwdata[31:0];

  ahb2_sram_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ahb2_sram_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(64), .WAIT_STATES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  ahb2_sram_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .WAIT_STATES(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [63:0] obs_rdata;
  logic        obs_ready;
  logic [1:0]  obs_resp;

  always_comb begin
    case (cur)
      1: begin obs_rdata = if1.hrdata;          obs_ready = if1.hreadyo; obs_resp = if1.hresp; end
      2: begin obs_rdata = {32'b0, if2.hrdata}; obs_ready = if2.hreadyo; obs_resp = if2.hresp; end
      default: begin obs_rdata = {32'b0, if0.hrdata}; obs_ready = if0.hreadyo; obs_resp = if0.hresp; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: dut=%h expected=%h (slave %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  function automatic int key(input int k, input int a);
    return k * (1 << 20) + a;
  endfunction

  function automatic bit is_illegal(input int k, input op_t o);
    int lb = (dw_of[k] == 64) ? 3 : 2;
    if (int'(o.size) > lb) return 1'b1;
    if ((o.addr % (32'd1 << o.size)) != 0) return 1'b1;
    if (o.addr >= (32'd1 << AW)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int k, input op_t o);
    int nb = dw_of[k] / 8;
    for (int b = 0; b < (1 << o.size); b++) begin
      int a;
      a = int'(o.addr) + b;
      ref_mem[key(k, a)] = o.data[8*(a % nb) +: 8];
    end
  endtask

  task automatic model_read(input int k, input op_t o, output logic [63:0] v, output logic [63:0] m);
    int nb = dw_of[k] / 8;
    int base = int'(o.addr) - (int'(o.addr) % nb);
    v = '0;
    m = '0;
    for (int l = 0; l < nb; l++) begin
      if (ref_mem.exists(key(k, base + l))) begin
        v[8*l +: 8] = ref_mem[key(k, base + l)];
        m[8*l +: 8] = 8'hFF;
      end
    end
  endtask

  function automatic op_t mk(input int kind, input bit wr, input logic [31:0] a, input logic [2:0] s,
                             input logic [63:0] d, input bit he, input logic [63:0] e);
    op_t o;
    o.kind = kind; o.wr = wr; o.addr = a; o.size = s; o.data = d; o.has_exp = he; o.exp = e;
    return o;
  endfunction

  function automatic op_t rnd_op(input int k);
    op_t o;
    int r = int'($urandom_range(0, 99));
    o.kind = (r < 8) ? int'($urandom_range(1, 3)) : 0;
    o.wr   = 1'($urandom_range(0, 1));
    o.size = (r < 90) ? 3'($urandom_range(0, (dw_of[k] == 64) ? 3 : 2)) : 3'($urandom_range(0, 7));
    o.addr = 32'($urandom_range(0, 'h7F));
    if ($urandom_range(0, 9) != 0) o.addr = o.addr & ~((32'd1 << o.size) - 32'd1);
    if ($urandom_range(0, 19) == 0) o.addr = o.addr | 32'h0004_0000;
    o.data = {$urandom, $urandom};
    o.has_exp = 1'b0;
    o.exp = '0;
    return o;
  endfunction

  task automatic present(input op_t o, input bit any);
    if (!any || o.kind == 1 || o.kind == 2) begin
      sel_en = 1'b1;
      htrans = (any && o.kind == 2) ? HTRANS_BUSY : HTRANS_IDLE;
      haddr  = any ? o.addr : $urandom;
      hwrite = 1'($urandom);
      hsize  = 3'($urandom);
    end else begin
      sel_en = (o.kind != 3);
      htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
      haddr  = o.addr;
      hwrite = o.wr;
      hsize  = o.size;
    end
  endtask

  // Entered and left at posedge+1; checks every cycle against the reference model.
  task automatic run(input op_t ops[$]);
    int n = 0;
    int left = 0;
    int cyc = 0;
    bit have = 1'b0;
    bit derr = 1'b0;
    op_t dp;
    logic exp_rdy;
    logic [1:0] exp_resp;
    logic [63:0] ev, em;
    dp = mk(1, 0, 0, 0, 0, 0, 0);
    present(ops[0], 1'b1);
    while (n < ops.size() || have) begin
      @(negedge clk);
      exp_rdy  = !(have && left > 0);
      exp_resp = (have && derr) ? HRESP_ERROR : HRESP_OKAY;
      ev = '0;
      em = '1;
      if (have && left == 0 && !derr && !dp.wr) model_read(cur, dp, ev, em);
      chk("hreadyo", 64'(obs_ready), 64'(exp_rdy));
      chk("hresp", 64'(obs_resp), 64'(exp_resp));
      chk("hrdata", obs_rdata & em, ev & em);
      if (have && left == 0 && !derr && !dp.wr && dp.has_exp) chk("hrdata_fixed", obs_rdata, dp.exp);
      if (have) begin
        if (left == 0) begin
          if (!derr && dp.wr) model_write(cur, dp);
          have = 1'b0;
        end else begin
          left--;
        end
      end
      if (exp_rdy && n < ops.size()) begin
        if (ops[n].kind == 0) begin
          dp   = ops[n];
          have = 1'b1;
          derr = is_illegal(cur, dp);
          left = derr ? 1 : ws_of[cur];
        end
        n++;
      end
      cyc++;
      if (cyc > 4000) begin
        chk("cycle_budget", 64'(cyc), 64'(4000));
        break;
      end
      @(posedge clk);
      #1;
      hwdata = have ? dp.data : {$urandom, $urandom};
      if (n < ops.size()) present(ops[n], 1'b1);
      else present(dp, 1'b0);
    end
  endtask

  initial begin
    op_t q[$];
    op_t o;
    sel_en = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = '0; hwdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      cur = k;
      #1;
      chk("rst_hreadyo", 64'(obs_ready), 64'd1);
      chk("rst_hresp", 64'(obs_resp), 64'(HRESP_OKAY));
      chk("rst_hrdata", obs_rdata, 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      cur = k;
      q = {};
      for (int a = 0; a < 'h500; a += dw_of[k] / 8)
        q.push_back(mk(0, 1, 32'(a), (dw_of[k] == 64) ? HSIZE_DWORD : HSIZE_WORD, {$urandom, $urandom}, 0, 0));
      run(q);
    end

    cur = 0;
    q = {};
    q.push_back(mk(0, 1, 32'h100, HSIZE_WORD, 64'hDEADBEEF, 0, 0));
    q.push_back(mk(0, 0, 32'h100, HSIZE_WORD, 0, 1, 64'hDEADBEEF));
    q.push_back(mk(0, 1, 32'h200, HSIZE_WORD, 64'h11223344, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 32'h202, HSIZE_BYTE, 64'h00AA0000, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 0, 32'h200, HSIZE_WORD, 0, 1, 64'h11AA3344));
    q.push_back(mk(0, 0, 32'h40000, HSIZE_WORD, 0, 0, 0));
    q.push_back(mk(0, 1, 32'h101, HSIZE_HALF, 64'hFFFFFFFF, 0, 0));
    q.push_back(mk(0, 1, 32'h100, HSIZE_DWORD, 64'h55555555, 0, 0));
    q.push_back(mk(0, 0, 32'h100, HSIZE_WORD, 0, 1, 64'hDEADBEEF));
    q.push_back(mk(0, 1, 32'h300, HSIZE_WORD, 64'hCAFEF00D, 0, 0));
    q.push_back(mk(0, 0, 32'h300, HSIZE_WORD, 0, 1, 64'hCAFEF00D));
    q.push_back(mk(2, 1, 32'h300, HSIZE_WORD, 0, 0, 0));
    q.push_back(mk(3, 1, 32'h300, HSIZE_WORD, 0, 0, 0));
    q.push_back(mk(0, 0, 32'h300, HSIZE_WORD, 0, 1, 64'hCAFEF00D));
    run(q);

    cur = 1;
    q = {};
    q.push_back(mk(0, 0, 32'h8, HSIZE_DWORD, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(0, 1, 32'h10, HSIZE_DWORD, 64'h0123456789ABCDEF, 0, 0));
    q.push_back(mk(0, 0, 32'h10, HSIZE_DWORD, 0, 1, 64'h0123456789ABCDEF));
    q.push_back(mk(0, 1, 32'h16, HSIZE_HALF, 64'hBEEF000000000000, 0, 0));
    q.push_back(mk(0, 0, 32'h10, HSIZE_WORD, 0, 1, 64'hBEEF456789ABCDEF));
    q.push_back(mk(0, 1, 32'h12, HSIZE_WORD, 64'hFFFFFFFFFFFFFFFF, 0, 0));
    q.push_back(mk(0, 0, 32'h4, 3'd4, 0, 0, 0));
    q.push_back(mk(0, 1, 32'h40008, HSIZE_DWORD, 64'hFFFFFFFFFFFFFFFF, 0, 0));
    q.push_back(mk(0, 0, 32'h10, HSIZE_DWORD, 0, 1, 64'hBEEF456789ABCDEF));
    run(q);

    cur = 2;
    q = {};
    q.push_back(mk(0, 1, 32'h300, HSIZE_WORD, 64'hCAFEF00D, 0, 0));
    q.push_back(mk(0, 0, 32'h300, HSIZE_WORD, 0, 1, 64'hCAFEF00D));
    run(q);

    o = mk(0, 1, 32'h400, HSIZE_WORD, 64'h0BADC0DE, 0, 0);
    present(o, 1'b1);
    htrans = HTRANS_NONSEQ;
    @(negedge clk);
    chk("wr400_accept_rdy", 64'(obs_ready), 64'd1);
    @(posedge clk);
    #1;
    hwdata = o.data;
    present(o, 1'b0);
    @(negedge clk);
    chk("wr400_wait_rdy", 64'(obs_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_hreadyo", 64'(obs_ready), 64'd1);
    chk("midrst_hresp", 64'(obs_resp), 64'(HRESP_OKAY));
    chk("midrst_hrdata", obs_rdata, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q = {};
    q.push_back(mk(0, 0, 32'h400, HSIZE_WORD, 0, 0, 0));
    q.push_back(mk(0, 1, 32'h404, HSIZE_WORD, 64'h600DF00D, 0, 0));
    q.push_back(mk(0, 0, 32'h404, HSIZE_WORD, 0, 1, 64'h600DF00D));
    run(q);

    for (int k = 0; k < 3; k++) begin
      cur = k;
      q = {};
      for (int i = 0; i < 150; i++) q.push_back(rnd_op(k));
      q.push_back(mk(0, 0, 32'h0, HSIZE_BYTE, 0, 0, 0));
      run(q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
